// File: rtl/hash_compute_unit.sv
`default_nettype none
// ============================================================================
// Module   : hash_compute_unit
// Purpose  : Streaming SHA-256 compression engine. The message schedule
//            W(t) arrives one word per beat on the input stream, and one
//            compression round runs per accepted beat. After 64 beats the
//            chaining value H0..H7 is updated. If the block was the last one,
//            the digest is offered on the output stream together with the
//            metadata captured at message start. SHA-384/512 messages are
//            accepted and discarded without producing a digest.
// Revision : 1.0 - initial release
//
// Ports
//   axis_aclk / axis_resetn : clock, asynchronous active-low reset
//   s_axis_tdata  [63:0]    : W(t) word in [31:0]; [63:32] ignored
//   s_axis_tuser  [127:0]   : metadata, sha_type in [33:32]
//   s_axis_tvalid/tready    : input handshake
//   s_axis_tlast            : high on word 63 of the final block
//   m_axis_tdata  [255:0]   : digest {H0..H7}, H0 in the MSBs
//   m_axis_tuser  [127:0]   : metadata captured at message start
//   m_axis_tvalid/tready    : output handshake
//   m_axis_tlast            : asserted together with m_axis_tvalid
//
// Configuration
//   HCU_SHA224_EN : when defined, sha_type == SHA224_type loads the SHA-224 IV
//                   and emits {H0..H6, 32'h0}. When undefined, SHA-224
//                   requests are processed exactly like SHA-256.
// ============================================================================

// sha_type encodings shared with the rest of the pipeline
`ifndef SHA224_type
`define SHA224_type 2'b00
`endif
`ifndef SHA256_type
`define SHA256_type 2'b01
`endif
`ifndef SHA384_type
`define SHA384_type 2'b10
`endif
`ifndef SHA512_type
`define SHA512_type 2'b11
`endif

module hash_compute_unit #(
  parameter int unsigned S_AXIS_DATA_WIDTH  = 64,
  parameter int unsigned M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                          axis_aclk,
  input  logic                          axis_resetn,
  input  logic [S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ROUND  = 3'd1,
    UPDATE = 3'd2,
    OUTPUT = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
`ifdef HCU_SHA224_EN
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
`endif

  // Round-constant ROM, indexed by the round counter
  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;  default: k = 32'hc67178f2;
    endcase
    return k;
  endfunction

  state_t      state, state_next;
  logic [5:0]  t;                       // round counter within the block
  logic        final_flag;              // current block is the last one
  logic [31:0] hv [8];                  // chaining value H0..H7
  logic [31:0] wv [8];                  // working variables a..h
  logic [M_AXIS_TUSER_WIDTH-1:0] tuser_q;
`ifdef HCU_SHA224_EN
  logic        is224;
`endif

  // FSM control strobes
  logic capture, round_en, update_en;

  // Only the low word carries W(t); the reduction keeps the rest visibly consumed
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata;

  // ---------------------------------------------------------------------------
  // Initial hash value selection
  // ---------------------------------------------------------------------------
  logic [31:0] iv [8];
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      iv[i] = IV256[i];
`ifdef HCU_SHA224_EN
      if (s_axis_tuser[33:32] == `SHA224_type) iv[i] = IV224[i];
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Round function
  // ---------------------------------------------------------------------------
  logic [31:0] va, vb, vc, vd, ve, vf, vg, vh;
  logic [31:0] big_s0, big_s1, ch, maj, t1, t2, w_in;

  assign {va, vb, vc, vd} = {wv[0], wv[1], wv[2], wv[3]};
  assign {ve, vf, vg, vh} = {wv[4], wv[5], wv[6], wv[7]};
  assign w_in = s_axis_tdata[31:0];

  always_comb begin
    big_s1 = {ve[5:0], ve[31:6]} ^ {ve[10:0], ve[31:11]} ^ {ve[24:0], ve[31:25]};
    big_s0 = {va[1:0], va[31:2]} ^ {va[12:0], va[31:13]} ^ {va[21:0], va[31:22]};
    ch     = (ve & vf) ^ (~ve & vg);
    maj    = (va & vb) ^ (va & vc) ^ (vb & vc);
    t1     = vh + big_s1 + ch + k_rom(t) + w_in;
    t2     = big_s0 + maj;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) state <= IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    capture       = 1'b0;
    round_en      = 1'b0;
    update_en     = 1'b0;
    case (state)
      IDLE: begin
        // Metadata is sampled here, but the pending word is left for ROUND
        if (s_axis_tvalid) begin
          capture    = 1'b1;
          state_next = s_axis_tuser[33] ? DRAIN : ROUND;
        end
      end
      ROUND: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          round_en = 1'b1;
          if (t == 6'd63) state_next = UPDATE;
        end
      end
      UPDATE: begin
        update_en  = 1'b1;
        state_next = final_flag ? OUTPUT : ROUND;
      end
      OUTPUT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) state_next = IDLE;
      end
      DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      for (int i = 0; i < 8; i++) begin
        hv[i] <= '0;
        wv[i] <= '0;
      end
      t          <= '0;
      final_flag <= 1'b0;
      tuser_q    <= '0;
`ifdef HCU_SHA224_EN
      is224      <= 1'b0;
`endif
    end else begin
      if (capture) begin
        tuser_q <= M_AXIS_TUSER_WIDTH'(s_axis_tuser);
        if (!s_axis_tuser[33]) begin
          for (int i = 0; i < 8; i++) begin
            hv[i] <= iv[i];
            wv[i] <= iv[i];
          end
          t          <= '0;
          final_flag <= 1'b0;
`ifdef HCU_SHA224_EN
          is224      <= (s_axis_tuser[33:32] == `SHA224_type);
`endif
        end
      end
      if (round_en) begin
        wv[0] <= t1 + t2;
        wv[1] <= va;
        wv[2] <= vb;
        wv[3] <= vc;
        wv[4] <= vd + t1;
        wv[5] <= ve;
        wv[6] <= vf;
        wv[7] <= vg;
        t     <= t + 6'd1;
        // tlast only carries meaning on the last word of a block
        if (t == 6'd63) final_flag <= s_axis_tlast;
      end
      if (update_en) begin
        for (int i = 0; i < 8; i++) begin
          hv[i] <= hv[i] + wv[i];
          wv[i] <= hv[i] + wv[i];
        end
        t <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output assembly
  // ---------------------------------------------------------------------------
  logic [255:0] digest;
  always_comb begin
    digest = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
`ifdef HCU_SHA224_EN
    if (is224) digest[31:0] = 32'h0;
`endif
  end

  assign m_axis_tdata = M_AXIS_DATA_WIDTH'(digest);
  assign m_axis_tuser = tuser_q;

endmodule

`default_nettype wire
